env_scan_reader: RTL and testbench
==================================

ENV_SCAN_READER -- requirements
Module: env_scan_reader

Interface
REQ-001 Clk  in  1  system clock (50 MHz); all state on rising edge.
REQ-002 Reset_n  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  single-cycle request to begin a full-grid read sweep; ignored unless idle.
REQ-004 lookup_X  out  X_bits  environment read column address.
REQ-005 lookup_Y  out  Y_bits  environment read row address.
REQ-006 lookup_sugar  in  1  sugar bit at the address presented one cycle earlier.
REQ-007 lookup_signal  in  SIGNAL_bits  signal value at the address presented one cycle earlier.
REQ-008 out_valid  out  1  out_data holds a valid cell record.
REQ-009 out_ready  in  1  consumer accepts the record when out_valid && out_ready.
REQ-010 out_data  out  X_bits+Y_bits+1+SIGNAL_bits  packed record {x, y, sugar, signal}, x in MSBs.
REQ-011 busy  out  1  high from start acceptance until done.
REQ-012 done  out  1  single-cycle pulse after the last record is accepted.
REQ-013 sugar_total  out  16  count of cells with sugar = 1 in the last completed sweep.
REQ-014 signal_sum  out  24  sum of signal over all cells in the last completed sweep.

Function
REQ-015 Sweep is raster order: x 0..GRID_W-1 inner, y 0..GRID_H-1 outer; GRID_W=160, GRID_H=120 (19200 cells).
REQ-016 Environment read latency is exactly one cycle; the reader captures lookup_sugar/lookup_signal one cycle after issuing lookup_X/lookup_Y.
REQ-017 Records go into a 4-entry FIFO feeding out_data; out_data is the FIFO head, out_valid = FIFO not empty.
REQ-018 Address issue stalls when FIFO occupancy plus in-flight reads would exceed 4; no record is ever dropped or duplicated.
REQ-019 States: IDLE -> (start) SCAN -> (last address issued) DRAIN -> (FIFO empty and no read in flight) DONE -> IDLE (one cycle).
REQ-020 done asserts only in DONE; busy = state != IDLE.
REQ-021 In IDLE, lookup_X/lookup_Y hold 0.
REQ-022 x wraps from GRID_W-1 to 0 with y incrementing; the sweep ends after (GRID_W-1, GRID_H-1); no address outside the grid is issued.
REQ-023 Running accumulators clear on start acceptance and update when a record enters the FIFO; sugar_total/signal_sum load from them on entering DONE and hold until the next DONE.
REQ-024 signal_sum saturates at 24'hFFFFFF; sugar_total cannot overflow (19200 < 65536).
REQ-025 start while busy is ignored; start and the final acceptance in the same cycle do not restart the sweep.
REQ-026 Simultaneous FIFO push and pop at full or empty occupancy is legal; occupancy is unchanged on a simultaneous push and pop.
REQ-027 out_data is stable while out_valid && !out_ready.

Reset
REQ-028 Reset_n low: state IDLE, FIFO empty, out_valid 0, busy 0, done 0, lookup_X/Y 0, accumulators, sugar_total and signal_sum 0.
REQ-029 Reset mid-sweep aborts without a done pulse; the next start begins at (0,0).

Structure
REQ-030 X_bits, Y_bits, SIGNAL_bits, GRID_W, GRID_H and the state enum live in the shared params package.
REQ-031 The FIFO is a sub-module, scan_fifo (depth and width parameters; push/pop/full/empty/count).

Verification
REQ-032 Constant environment (sugar=0, signal=3), out_ready=1 -> 19200 records in raster order, done once, sugar_total=0, signal_sum=57600.
REQ-033 Sugar only at (5,7) and (159,119) -> exactly two records with sugar=1 at those coordinates, sugar_total=2.
REQ-034 out_ready toggles 1 cycle on / 3 off -> same 19200 record sequence as REQ-032, occupancy never exceeds 4, out_data stable while stalled.
REQ-035 Reset_n pulsed low at record 1000, then start -> outputs at reset values, no done pulse before the reset, new sweep begins at (0,0).
REQ-036 start re-pulsed at cycle 50 of a sweep -> ignored, exactly 19200 records and one done pulse.
REQ-037 Signal at maximum value everywhere with SIGNAL_bits widened so the sum exceeds 24 bits -> signal_sum = 24'hFFFFFF.

Source files
------------

// File: rtl/env_scan_reader_pkg.sv
// Shared parameters and types for the environment scan reader.
//   X_bits/Y_bits/SIGNAL_bits : field widths of an environment cell record
//   GRID_W/GRID_H             : grid dimensions swept in raster order
//   FIFO_DEPTH/REC_W          : output FIFO geometry
//   scan_state_t              : sweep controller states
//   sat_add24                 : saturating accumulate into a 24-bit sum
package env_scan_reader_pkg;

    localparam int unsigned X_bits      = 8;
    localparam int unsigned Y_bits      = 7;
    // 10 bits lets a full-grid sum of maximum signal exceed 24 bits.
    localparam int unsigned SIGNAL_bits = 10;
    localparam int unsigned GRID_W      = 160;
    localparam int unsigned GRID_H      = 120;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned REC_W       = X_bits + Y_bits + 1 + SIGNAL_bits;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    function automatic logic [23:0] sat_add24(input logic [23:0]            acc,
                                              input logic [SIGNAL_bits-1:0] val);
        logic [24:0] sum;
        sum = {1'b0, acc} + 25'(val);
        return sum[24] ? '1 : sum[23:0];
    endfunction

endpackage

// File: rtl/env_scan_reader_fifo.sv
// scan_fifo: small synchronous FIFO holding cell records for the consumer.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (accepted when not full, or when popping)
//   pop        : advance the head (ignored when empty)
//   pop_data   : current head entry
//   full/empty : occupancy flags
//   count      : current occupancy 0..DEPTH
module scan_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so push at full is legal then.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/env_scan_reader.sv
// env_scan_reader: sweeps the whole environment grid in raster order, reads
// sugar/signal per cell through a one-cycle-latency lookup port, and streams
// {x, y, sugar, signal} records through a 4-entry FIFO with valid/ready.
//   Clk, Reset_n          : clock, asynchronous active-low reset
//   start                 : begin a sweep (only honoured in IDLE)
//   lookup_X/lookup_Y     : environment read address
//   lookup_sugar/_signal  : read data for the address of the previous cycle
//   out_valid/out_ready   : record handshake, out_data = FIFO head
//   busy, done            : sweep in progress / one-cycle completion pulse
//   sugar_total/signal_sum: totals of the last completed sweep
module env_scan_reader
    import env_scan_reader_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   start,
    output logic [X_bits-1:0]      lookup_X,
    output logic [Y_bits-1:0]      lookup_Y,
    input  logic                   lookup_sugar,
    input  logic [SIGNAL_bits-1:0] lookup_signal,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [REC_W-1:0]       out_data,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            sugar_total,
    output logic [23:0]            signal_sum
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    scan_state_t       state;
    scan_state_t       state_nxt;

    logic [X_bits-1:0] x_cnt;
    logic [Y_bits-1:0] y_cnt;
    logic              rd_pending;
    logic [X_bits-1:0] rd_x;
    logic [Y_bits-1:0] rd_y;

    logic              issue;
    logic              last_addr;
    logic              start_ok;
    logic              credit_ok;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [REC_W-1:0]  rec_in;

    logic [15:0]       acc_sugar;
    logic [23:0]       acc_signal;

    // Counters wrap back to (0,0) after the last cell, so IDLE presents 0.
    assign lookup_X  = x_cnt;
    assign lookup_Y  = y_cnt;

    assign start_ok  = (state == ST_IDLE) && start;
    assign last_addr = (x_cnt == X_bits'(GRID_W - 1)) && (y_cnt == Y_bits'(GRID_H - 1));
    // Occupancy plus the read in flight must leave room for one more record.
    assign credit_ok = (32'(fifo_count) + 32'(rd_pending)) < FIFO_DEPTH;

    assign rec_in    = {rd_x, rd_y, lookup_sugar, lookup_signal};
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)                    state_nxt = ST_SCAN;
            ST_SCAN:  if (issue && last_addr)       state_nxt = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && !rd_pending) state_nxt = ST_DONE;
            ST_DONE:                                state_nxt = ST_IDLE;
            default:                                state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy  = (state != ST_IDLE);
        done  = (state == ST_DONE);
        issue = (state == ST_SCAN) && credit_ok && !fifo_full;
    end

    // Address generation, read tracking and accumulators
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            rd_pending  <= 1'b0;
            rd_x        <= '0;
            rd_y        <= '0;
            acc_sugar   <= '0;
            acc_signal  <= '0;
            sugar_total <= '0;
            signal_sum  <= '0;
        end else begin
            rd_pending <= issue;
            if (issue) begin
                rd_x <= x_cnt;
                rd_y <= y_cnt;
            end

            if (start_ok) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (issue) begin
                if (x_cnt == X_bits'(GRID_W - 1)) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == Y_bits'(GRID_H - 1)) ? '0 : y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end

            // rd_pending marks the cycle the record is pushed into the FIFO.
            if (start_ok) begin
                acc_sugar  <= '0;
                acc_signal <= '0;
            end else if (rd_pending) begin
                acc_sugar  <= acc_sugar + 16'(lookup_sugar);
                acc_signal <= sat_add24(acc_signal, lookup_signal);
            end

            if ((state == ST_DRAIN) && (state_nxt == ST_DONE)) begin
                sugar_total <= acc_sugar;
                signal_sum  <= acc_signal;
            end
        end
    end

    scan_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .push      (rd_pending),
        .push_data (rec_in),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_env_scan_reader.sv
// Directed bench for env_scan_reader: full sweeps with a modelled
// environment, consumer back-pressure, restart attempts and mid-sweep reset.
module tb_env_scan_reader;
    import env_scan_reader_pkg::*;

    localparam int unsigned N_CELLS = GRID_W * GRID_H;

    logic                   Clk = 1'b0;
    logic                   Reset_n;
    logic                   start;
    logic [X_bits-1:0]      lookup_X;
    logic [Y_bits-1:0]      lookup_Y;
    logic                   lookup_sugar;
    logic [SIGNAL_bits-1:0] lookup_signal;
    logic                   out_valid;
    logic                   out_ready;
    logic [REC_W-1:0]       out_data;
    logic                   busy;
    logic                   done;
    logic [15:0]            sugar_total;
    logic [23:0]            signal_sum;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int          env_mode;      // 1: sugar at two cells, max signal; 2: no sugar, signal 3
    int          ready_mode;    // 0: always ready; 1: 1-on/3-off for the first 2000 records
    bit          restart_en;    // pulse start at sweep cycle 50
    bit          last_start_en; // pulse start with the final acceptance
    bit          start_req;
    int unsigned scyc;
    int unsigned n_rec;
    int unsigned n_sugar;
    int unsigned done_cnt;
    bit          stalled;
    logic [REC_W-1:0] held;

    always #10 Clk = ~Clk;

    env_scan_reader dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .start         (start),
        .lookup_X      (lookup_X),
        .lookup_Y      (lookup_Y),
        .lookup_sugar  (lookup_sugar),
        .lookup_signal (lookup_signal),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .done          (done),
        .sugar_total   (sugar_total),
        .signal_sum    (signal_sum)
    );

    function automatic logic env_sugar(input int unsigned x, input int unsigned y);
        return (env_mode == 1) && (((x == 5) && (y == 7)) || ((x == 159) && (y == 119)));
    endfunction

    function automatic logic [SIGNAL_bits-1:0] env_signal();
        return (env_mode == 1) ? {SIGNAL_bits{1'b1}} : SIGNAL_bits'(3);
    endfunction

    // Environment memory model: one-cycle read latency.
    always @(posedge Clk) begin
        lookup_sugar  <= env_sugar(int'(lookup_X), int'(lookup_Y));
        lookup_signal <= env_signal();
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: observe at the falling edge, then drive for the next rising edge.
    task automatic step();
        logic [X_bits-1:0]      rx;
        logic [Y_bits-1:0]      ry;
        logic                   rs;
        logic [SIGNAL_bits-1:0] rsig;
        @(negedge Clk);
        scyc++;
        if (Reset_n) begin
            if (stalled) begin
                check_val("hold_valid", 32'(out_valid), 32'd1);
                check_val("hold_data", 32'(out_data), 32'(held));
            end
            if (done) done_cnt++;
        end
        out_ready = (ready_mode == 0) || (scyc % 4 == 0) || (n_rec >= 2000);
        start     = start_req || (restart_en && (scyc == 50));
        start_req = 1'b0;
        stalled   = 1'b0;
        if (Reset_n && out_valid) begin
            if (out_ready) begin
                rx   = out_data[REC_W-1 -: X_bits];
                ry   = out_data[SIGNAL_bits+1 +: Y_bits];
                rs   = out_data[SIGNAL_bits];
                rsig = out_data[SIGNAL_bits-1:0];
                check_val("rec_x", 32'(rx), n_rec % GRID_W);
                check_val("rec_y", 32'(ry), n_rec / GRID_W);
                check_val("rec_sugar", 32'(rs), 32'(env_sugar(n_rec % GRID_W, n_rec / GRID_W)));
                check_val("rec_signal", 32'(rsig), 32'(env_signal()));
                if (last_start_en && (n_rec == N_CELLS - 1)) start = 1'b1;
                n_rec++;
                n_sugar += 32'(rs);
            end else begin
                stalled = 1'b1;
                held    = out_data;
                check_val("occupancy_le_4", 32'(dut.u_fifo.count <= 3'd4), 32'd1);
            end
        end
    endtask

    task automatic run_sweep(input int mode, input int rmode, input bit restart,
                             input bit last_start, input int unsigned exp_sugar,
                             input logic [23:0] exp_sum);
        env_mode      = mode;
        ready_mode    = rmode;
        restart_en    = restart;
        last_start_en = last_start;
        n_rec         = 0;
        n_sugar       = 0;
        done_cnt      = 0;
        scyc          = 0;
        stalled       = 1'b0;
        start_req     = 1'b1;
        step();
        step();
        check_val("busy_after_start", 32'(busy), 32'd1);
        while ((done_cnt == 0) && (scyc < 60000)) step();
        check_val("done_seen", done_cnt, 32'd1);
        check_val("record_count", n_rec, N_CELLS);
        check_val("sugar_records", n_sugar, exp_sugar);
        check_val("sugar_total", 32'(sugar_total), exp_sugar);
        check_val("signal_sum", 32'(signal_sum), 32'(exp_sum));
        repeat (5) step();
        check_val("idle_after_done", 32'(busy), 32'd0);
        check_val("single_done", done_cnt, 32'd1);
        check_val("no_extra_records", n_rec, N_CELLS);
        check_val("idle_addr_x", 32'(lookup_X), 32'd0);
        check_val("idle_addr_y", 32'(lookup_Y), 32'd0);
    endtask

    initial begin
        Reset_n    = 1'b0;
        start      = 1'b0;
        start_req  = 1'b0;
        out_ready  = 1'b0;
        env_mode   = 2;
        ready_mode = 0;
        restart_en = 1'b0;
        last_start_en = 1'b0;
        stalled    = 1'b0;
        repeat (3) @(negedge Clk);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_sugar_total", 32'(sugar_total), 32'd0);
        check_val("rst_signal_sum", 32'(signal_sum), 32'd0);
        Reset_n = 1'b1;
        step();
        check_val("idle_busy", 32'(busy), 32'd0);

        // Sugar at two cells, saturating signal, back-pressure, restart attempt.
        run_sweep(1, 1, 1'b1, 1'b0, 2, 24'hFFFFFF);

        // Mid-sweep reset at record 1000.
        env_mode   = 2;
        ready_mode = 0;
        restart_en = 1'b0;
        last_start_en = 1'b0;
        n_rec      = 0;
        done_cnt   = 0;
        scyc       = 0;
        start_req  = 1'b1;
        while ((n_rec < 1000) && (scyc < 5000)) step();
        check_val("reached_rec_1000", n_rec, 32'd1000);
        check_val("no_done_before_reset", done_cnt, 32'd0);
        Reset_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_done", 32'(done), 32'd0);
        check_val("mid_rst_x", 32'(lookup_X), 32'd0);
        check_val("mid_rst_y", 32'(lookup_Y), 32'd0);
        check_val("mid_rst_sugar_total", 32'(sugar_total), 32'd0);
        check_val("mid_rst_signal_sum", 32'(signal_sum), 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        stalled = 1'b0;

        // Constant environment, always ready, start alongside final acceptance.
        run_sweep(2, 0, 1'b0, 1'b1, 0, 24'd57600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
